// File: rtl/quad_port_ram_arbiter.sv
// Four-requester arbiter in front of a RAM with two read/write ports (A, B) and
// two read-only ports (C, D); rotating priority, address-hazard checks, 1-cycle read return.
module quad_port_ram_arbiter #(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 req,
  input  logic [3:0]                 we,
  input  logic [4*ADDRESS_SPACE-1:0] addr,
  input  logic [4*DATA_SIZE-1:0]     wdata,
  output logic [3:0]                 gnt,
  output logic [3:0]                 rvalid,
  output logic [4*DATA_SIZE-1:0]     rdata,
  output logic [ADDRESS_SPACE-1:0]   ram_addr_a,
  output logic [ADDRESS_SPACE-1:0]   ram_addr_b,
  output logic [ADDRESS_SPACE-1:0]   ram_addr_c,
  output logic [ADDRESS_SPACE-1:0]   ram_addr_d,
  output logic [DATA_SIZE-1:0]       ram_data_a,
  output logic [DATA_SIZE-1:0]       ram_data_b,
  output logic                       ram_we_a,
  output logic                       ram_we_b,
  input  logic [DATA_SIZE-1:0]       ram_q_a,
  input  logic [DATA_SIZE-1:0]       ram_q_b,
  input  logic [DATA_SIZE-1:0]       ram_q_c,
  input  logic [DATA_SIZE-1:0]       ram_q_d
);

  localparam int AW = ADDRESS_SPACE;
  localparam int DW = DATA_SIZE;

  logic [AW-1:0] addr_arr  [4];
  logic [DW-1:0] wdata_arr [4];
  logic [DW-1:0] q_arr     [4];

  logic [1:0]    ptr;
  logic [3:0]    gnt_c;
  logic [3:0]    port_vld;
  logic [3:0]    port_wr;
  logic [1:0]    port_id [4];
  logic [1:0]    cur;
  logic [1:0]    hi;
  logic [1:0]    slot;
  logic          blocked;
  logic          placed;

  logic [3:0]    own_vld_p1;
  logic [1:0]    own_id_p1 [4];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      addr_arr[n]  = addr[n*AW +: AW];
      wdata_arr[n] = wdata[n*DW +: DW];
    end
    q_arr[0] = ram_q_a;
    q_arr[1] = ram_q_b;
    q_arr[2] = ram_q_c;
    q_arr[3] = ram_q_d;
  end

  // Port index 0..3 maps to A, B, C, D; writes fill A/B first, reads then take C, D, A, B.
  always_comb begin
    gnt_c    = '0;
    port_vld = '0;
    port_wr  = '0;
    cur      = '0;
    hi       = '0;
    slot     = '0;
    blocked  = 1'b0;
    placed   = 1'b0;
    for (int p = 0; p < 4; p++) port_id[p] = '0;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        cur = ptr + 2'(k);
        if (req[cur] && we[cur]) begin
          blocked = 1'b0;
          for (int j = 0; j < k; j++) begin
            hi = ptr + 2'(j);
            if (req[hi] && (addr_arr[hi] == addr_arr[cur]) && (!we[hi] || gnt_c[hi]))
              blocked = 1'b1;
          end
          if (!blocked && !port_vld[0]) begin
            port_vld[0] = 1'b1;
            port_wr[0]  = 1'b1;
            port_id[0]  = cur;
            gnt_c[cur]  = 1'b1;
          end else if (!blocked && !port_vld[1]) begin
            port_vld[1] = 1'b1;
            port_wr[1]  = 1'b1;
            port_id[1]  = cur;
            gnt_c[cur]  = 1'b1;
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        cur = ptr + 2'(k);
        if (req[cur] && !we[cur]) begin
          blocked = 1'b0;
          for (int p = 0; p < 2; p++) begin
            if (port_wr[p] && (addr_arr[port_id[p]] == addr_arr[cur]))
              blocked = 1'b1;
          end
          placed = blocked;
          for (int s = 0; s < 4; s++) begin
            slot = 2'(s + 2);
            if (!placed && !port_vld[slot]) begin
              port_vld[slot] = 1'b1;
              port_id[slot]  = cur;
              gnt_c[cur]     = 1'b1;
              placed         = 1'b1;
            end
          end
        end
      end
    end
  end

  assign gnt = gnt_c;

  always_comb begin
    ram_addr_a = port_vld[0] ? addr_arr[port_id[0]] : '0;
    ram_addr_b = port_vld[1] ? addr_arr[port_id[1]] : '0;
    ram_addr_c = port_vld[2] ? addr_arr[port_id[2]] : '0;
    ram_addr_d = port_vld[3] ? addr_arr[port_id[3]] : '0;
    ram_data_a = port_wr[0] ? wdata_arr[port_id[0]] : '0;
    ram_data_b = port_wr[1] ? wdata_arr[port_id[1]] : '0;
    ram_we_a   = port_wr[0];
    ram_we_b   = port_wr[1];
  end

  // Stage p1: read ownership per port, aligned with the RAM's registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 2'd0;
      own_vld_p1 <= '0;
    end else begin
      if (|(req & ~gnt_c)) ptr <= ptr + 2'd1;
      own_vld_p1 <= port_vld & ~port_wr;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) own_id_p1[p] <= port_id[p];
  end

  // A read in flight when reset arrives is dropped rather than returned.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        if (own_vld_p1[p]) begin
          rvalid[own_id_p1[p]] = 1'b1;
          rdata[int'(own_id_p1[p])*DW +: DW] = q_arr[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_port_ram_arbiter.sv
// Directed bench for quad_port_ram_arbiter: a RAM environment, a queue-based
// reference model compared every cycle, and hand-computed literal checks.
module tb_quad_port_ram_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   r_req = '0;
  logic [3:0]   r_we  = '0;
  logic [11:0]  r_addr  [4];
  logic [31:0]  r_wdata [4];
  logic [47:0]  addr_bus;
  logic [127:0] wdata_bus;

  logic [3:0]   gnt, rvalid;
  logic [127:0] rdata;
  logic [11:0]  ram_addr_a, ram_addr_b, ram_addr_c, ram_addr_d;
  logic [31:0]  ram_data_a, ram_data_b;
  logic         ram_we_a, ram_we_b;
  logic [31:0]  ram_q_a, ram_q_b, ram_q_c, ram_q_d;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram_mem [4096];
  logic [31:0] mdl_mem [4096];
  int          ptr_m = 0;
  logic [3:0]  exp_rv = '0;
  logic [31:0] exp_rd [4];

  assign addr_bus  = {r_addr[3], r_addr[2], r_addr[1], r_addr[0]};
  assign wdata_bus = {r_wdata[3], r_wdata[2], r_wdata[1], r_wdata[0]};

  quad_port_ram_arbiter #(.ADDRESS_SPACE(12), .DATA_SIZE(32)) dut (
    .clk(clk), .rst(rst), .req(r_req), .we(r_we), .addr(addr_bus), .wdata(wdata_bus),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_addr_c(ram_addr_c), .ram_addr_d(ram_addr_d),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b), .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b), .ram_q_c(ram_q_c), .ram_q_d(ram_q_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // RAM environment: two write ports, four registered read ports, read-old-data.
  always @(posedge clk) begin
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= ram_mem[ram_addr_a];
    ram_q_b <= ram_mem[ram_addr_b];
    ram_q_c <= ram_mem[ram_addr_c];
    ram_q_d <= ram_mem[ram_addr_d];
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: grants follow from address claims in priority order.
  always @(negedge clk) begin : model
    logic [3:0]  g;
    int          wq[$];
    int          rq[$];
    int          fr[$];
    logic [11:0] seen[$];
    logic [11:0] wa[$];
    logic [11:0] ea [4];
    logic [31:0] ed [2];
    logic [1:0]  ewe;
    int          i;
    bit          ok;

    check("rvalid", 128'(rvalid), rst ? 128'd0 : 128'(exp_rv));
    for (int n = 0; n < 4; n++)
      check($sformatf("rdata%0d", n), 128'(rdata[n*32 +: 32]),
            (rst || !exp_rv[n]) ? 128'd0 : 128'(exp_rd[n]));

    g = '0;
    wq.delete(); rq.delete(); fr.delete(); seen.delete(); wa.delete();
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        i = (ptr_m + k) % 4;
        if (r_req[i] && r_we[i]) begin
          ok = (wq.size() < 2);
          foreach (seen[s]) if (seen[s] == r_addr[i]) ok = 0;
          foreach (wa[s])   if (wa[s] == r_addr[i])   ok = 0;
          if (ok) begin g[i] = 1'b1; wq.push_back(i); wa.push_back(r_addr[i]); end
        end else if (r_req[i]) begin
          seen.push_back(r_addr[i]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        i = (ptr_m + k) % 4;
        if (r_req[i] && !r_we[i]) begin
          ok = (wq.size() + rq.size() < 4);
          foreach (wa[s]) if (wa[s] == r_addr[i]) ok = 0;
          if (ok) begin g[i] = 1'b1; rq.push_back(i); end
        end
      end
    end
    fr.push_back(2);
    fr.push_back(3);
    if (wq.size() < 1) fr.push_back(0);
    if (wq.size() < 2) fr.push_back(1);
    for (int p = 0; p < 4; p++) ea[p] = '0;
    ed[0] = '0; ed[1] = '0; ewe = '0;
    foreach (wq[n]) begin ea[n] = r_addr[wq[n]]; ed[n] = r_wdata[wq[n]]; ewe[n] = 1'b1; end
    foreach (rq[n]) ea[fr[n]] = r_addr[rq[n]];

    check("gnt", 128'(gnt), 128'(g));
    check("ram_we_ab", 128'({ram_we_a, ram_we_b}), 128'({ewe[0], ewe[1]}));
    check("ram_addr_a", 128'(ram_addr_a), 128'(ea[0]));
    check("ram_addr_b", 128'(ram_addr_b), 128'(ea[1]));
    check("ram_addr_c", 128'(ram_addr_c), 128'(ea[2]));
    check("ram_addr_d", 128'(ram_addr_d), 128'(ea[3]));
    check("ram_data_a", 128'(ram_data_a), 128'(ed[0]));
    check("ram_data_b", 128'(ram_data_b), 128'(ed[1]));

    if (rst) begin
      ptr_m  = 0;
      exp_rv = '0;
    end else begin
      if (|(r_req & ~g)) ptr_m = (ptr_m + 1) % 4;
      exp_rv = '0;
      foreach (rq[n]) begin exp_rv[rq[n]] = 1'b1; exp_rd[rq[n]] = mdl_mem[r_addr[rq[n]]]; end
      foreach (wq[n]) mdl_mem[r_addr[wq[n]]] = r_wdata[wq[n]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input bit w, input logic [11:0] a);
    r_req[i]   = 1'b1;
    r_we[i]    = w;
    r_addr[i]  = a;
    r_wdata[i] = 32'hD0000000 | 32'(a);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_rq(i, 1'b1, 12'(i + 1));
    tick();
    @(negedge clk);
    check("rst_gnt", 128'(gnt), 128'd0);
    check("rst_we", 128'({ram_we_a, ram_we_b}), 128'd0);
    tick();
    r_req = '0;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int granted_at;
    for (int a = 0; a < 4096; a++) begin
      ram_mem[a] = init_val(a);
      mdl_mem[a] = init_val(a);
    end
    for (int i = 0; i < 4; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; exp_rd[i] = '0;
    end

    // Four reads to distinct addresses fill C, D, A, B in priority order.
    reset_dut();
    for (int i = 0; i < 4; i++) set_rq(i, 1'b0, 12'(i + 1));
    @(negedge clk);
    check("four_reads_gnt", 128'(gnt), 128'(4'b1111));
    check("four_reads_port_c", 128'(ram_addr_c), 128'd1);
    check("four_reads_port_b", 128'(ram_addr_b), 128'd4);
    tick();
    r_req = '0;
    @(negedge clk);
    check("four_reads_rvalid", 128'(rvalid), 128'(4'b1111));
    check("four_reads_rdata0", 128'(rdata[31:0]), 128'(32'hC0DE0001));
    check("four_reads_rdata3", 128'(rdata[127:96]), 128'(32'hC0DE0004));

    // Four writes: two per cycle, denial rotates the pointer.
    reset_dut();
    for (int i = 0; i < 4; i++) set_rq(i, 1'b1, 12'(16'h0A0 + i));
    @(negedge clk);
    check("four_writes_c1", 128'(gnt), 128'(4'b0011));
    tick();
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    @(negedge clk);
    check("four_writes_c2", 128'(gnt), 128'(4'b1100));
    check("four_writes_a", 128'(ram_addr_a), 128'(12'h0A2));
    check("four_writes_b", 128'(ram_addr_b), 128'(12'h0A3));
    tick();
    r_req = '0;

    // Read after write to the same address sees the new data.
    reset_dut();
    set_rq(0, 1'b1, 12'h010);
    r_wdata[0] = 32'h000000AA;
    set_rq(1, 1'b0, 12'h010);
    @(negedge clk);
    check("raw_c1", 128'(gnt), 128'(4'b0001));
    tick();
    r_req[0] = 1'b0;
    @(negedge clk);
    check("raw_c2", 128'(gnt), 128'(4'b0010));
    tick();
    r_req = '0;
    @(negedge clk);
    check("raw_rdata1", 128'(rdata[63:32]), 128'(32'h000000AA));

    // Higher-priority read blocks a write to the same address.
    reset_dut();
    set_rq(0, 1'b0, 12'h020);
    set_rq(1, 1'b1, 12'h020);
    @(negedge clk);
    check("war_c1", 128'(gnt), 128'(4'b0001));
    tick();
    r_req[0] = 1'b0;
    @(negedge clk);
    check("war_c2", 128'(gnt), 128'(4'b0010));
    check("war_rdata0", 128'(rdata[31:0]), 128'(32'hC0DE0020));
    tick();
    r_req = '0;

    // Same-address reads, three writes plus a read, and a mixed hazard.
    reset_dut();
    for (int i = 0; i < 4; i++) set_rq(i, 1'b0, 12'h007);
    @(negedge clk);
    check("same_addr_reads", 128'(gnt), 128'(4'b1111));
    reset_dut();
    for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 12'(i + 1));
    set_rq(3, 1'b0, 12'h009);
    @(negedge clk);
    check("three_w_one_r", 128'(gnt), 128'(4'b1011));
    check("three_w_one_r_c", 128'(ram_addr_c), 128'(12'h009));
    reset_dut();
    set_rq(0, 1'b0, 12'h041);
    set_rq(1, 1'b0, 12'h040);
    set_rq(2, 1'b1, 12'h040);
    @(negedge clk);
    check("mixed_hazard", 128'(gnt), 128'(4'b0011));
    tick();
    r_req = '0;
    @(negedge clk);
    check("idle_gnt", 128'(gnt), 128'd0);

    // Starvation bound: req3 writes while 0..2 keep writing fresh addresses.
    reset_dut();
    granted_at = 0;
    set_rq(3, 1'b1, 12'h033);
    for (int c = 0; c < 6 && granted_at == 0; c++) begin
      for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 12'(16'h100 + c*4 + i));
      @(negedge clk);
      if (gnt[3]) granted_at = c + 1;
      tick();
    end
    r_req = '0;
    check("req3_wait_cycles", 128'(granted_at), 128'd3);

    // Read in flight when reset arrives is discarded; pointer restarts at 0.
    reset_dut();
    set_rq(0, 1'b0, 12'h005);
    @(negedge clk);
    check("flush_gnt", 128'(gnt), 128'(4'b0001));
    tick();
    r_req = '0;
    rst = 1'b1;
    @(negedge clk);
    check("flush_rvalid_1", 128'(rvalid), 128'd0);
    tick();
    @(negedge clk);
    check("flush_rvalid_2", 128'(rvalid), 128'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_rq(i, 1'b1, 12'(16'h200 + i));
    @(negedge clk);
    check("post_rst_gnt", 128'(gnt), 128'(4'b0011));
    tick();
    r_req = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
